// File: rtl/coin_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : coin_counter_if
//  Description : Bundles the coin-mech, dispenser and change-ejector signals
//                of the coin_counter credit stage.
//                  coin_nickel/dime/quarter/dollar : coin mech levels
//                  refund_req                      : refund button level
//                  vend_done, change_in[9:0]       : dispenser vend report
//                  credit[9:0]                     : credit in cents
//                  coin_reject                     : coin not credited
//                  change_nickel, change_quarter   : change eject pulses
//                  refund_busy                     : refund in progress
//                master modport : environment (coin mech + dispenser)
//                slave  modport : coin_counter
//  Revision    : 1.0  initial release
// ============================================================================
interface coin_counter_if;
    logic       coin_nickel;
    logic       coin_dime;
    logic       coin_quarter;
    logic       coin_dollar;
    logic       refund_req;
    logic       vend_done;
    logic [9:0] change_in;
    logic [9:0] credit;
    logic       coin_reject;
    logic       change_nickel;
    logic       change_quarter;
    logic       refund_busy;

    modport master (
        output coin_nickel, coin_dime, coin_quarter, coin_dollar,
        output refund_req, vend_done, change_in,
        input  credit, coin_reject, change_nickel, change_quarter, refund_busy
    );

    modport slave (
        input  coin_nickel, coin_dime, coin_quarter, coin_dollar,
        input  refund_req, vend_done, change_in,
        output credit, coin_reject, change_nickel, change_quarter, refund_busy
    );
endinterface
`default_nettype wire

// File: rtl/coin_counter.sv
`default_nettype none
// ============================================================================
//  Module      : coin_counter
//  Description : Upstream credit stage of the vending path. Detects coin
//                insertions, accumulates credit (cents), takes back the
//                dispenser's remaining money after each vend and pays out
//                remaining credit as timed change pulses on refund.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous, active-low reset
//                bus  - coin_counter_if.slave (coins, refund_req, vend_done,
//                       change_in in; credit, coin_reject, change_nickel,
//                       change_quarter, refund_busy out)
//  Parameters  : MAX_CREDIT - credit ceiling in cents (<= 1023)
//                REFUND_GAP - cycles between change pulses (>= 2)
//  Options     : COIN_COUNTER_QUARTER_CHANGE_EN - refund pays quarters while
//                credit >= 25, nickels otherwise; when undefined the refund
//                is nickels only and change_quarter is held at 0.
//  Revision    : 1.0  initial release
// ============================================================================
module coin_counter #(
    parameter int MAX_CREDIT = 995,
    parameter int REFUND_GAP = 4
) (
    input logic           clk,
    input logic           rst,
    coin_counter_if.slave bus
);

    localparam int               GAP_W        = $clog2(REFUND_GAP);
    localparam logic [GAP_W-1:0] c_gap_reload = GAP_W'(REFUND_GAP - 1);
    localparam logic [10:0]      c_max_credit = 11'(MAX_CREDIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_REFUND = 2'd2
    } state_t;

    state_t           state_q,         state_d;
    logic [9:0]       credit_q,        credit_d;
    logic [GAP_W-1:0] gap_q,           gap_d;
    logic [4:0]       prev_q,          prev_d;   // {refund, dollar, quarter, dime, nickel}
    logic             coin_reject_q,   coin_reject_d;
    logic             change_nickel_q, change_nickel_d;
    logic             refund_busy_q,   refund_busy_d;
`ifdef COIN_COUNTER_QUARTER_CHANGE_EN
    logic             change_quarter_q, change_quarter_d;
`endif

    logic [4:0]  w_sample;
    logic [4:0]  w_edge;
    logic        w_any_coin;
    logic [10:0] w_coin_sum;
    logic [10:0] w_credit_sum;
    logic [9:0]  w_change_clamped;

    assign w_sample   = {bus.refund_req, bus.coin_dollar, bus.coin_quarter,
                         bus.coin_dime, bus.coin_nickel};
    assign w_edge     = w_sample & ~prev_q;
    assign w_any_coin = |w_edge[3:0];

    // Several coins may land in one cycle; they are credited (or rejected) as a group.
    assign w_coin_sum = (w_edge[0] ? 11'd5   : 11'd0)
                      + (w_edge[1] ? 11'd10  : 11'd0)
                      + (w_edge[2] ? 11'd25  : 11'd0)
                      + (w_edge[3] ? 11'd100 : 11'd0);
    assign w_credit_sum = {1'b0, credit_q} + w_coin_sum;

    assign w_change_clamped = ({1'b0, bus.change_in} > c_max_credit) ?
                              c_max_credit[9:0] : bus.change_in;

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        gap_d           = gap_q;
        prev_d          = w_sample;
        coin_reject_d   = 1'b0;
        change_nickel_d = 1'b0;
`ifdef COIN_COUNTER_QUARTER_CHANGE_EN
        change_quarter_d = 1'b0;
`endif
        case (state_q)
            ST_REFUND: begin
                // Coins are never credited while change is being paid out.
                coin_reject_d = w_any_coin;
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
`ifdef COIN_COUNTER_QUARTER_CHANGE_EN
                end else if (credit_q >= 10'd25) begin
                    credit_d         = credit_q - 10'd25;
                    change_quarter_d = 1'b1;
                    gap_d            = c_gap_reload;
`endif
                end else if (credit_q >= 10'd5) begin
                    credit_d        = credit_q - 10'd5;
                    change_nickel_d = 1'b1;
                    gap_d           = c_gap_reload;
                end else begin
                    // Sub-nickel remainder cannot be paid out and is forfeited.
                    credit_d = 10'd0;
                    gap_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                if (w_edge[4] && (state_q == ST_CREDIT)) begin
                    state_d       = ST_REFUND;
                    gap_d         = '0;  // first pulse on the very next cycle
                    coin_reject_d = w_any_coin;
                end else begin
                    if (bus.vend_done) begin
                        credit_d      = w_change_clamped;
                        coin_reject_d = w_any_coin;
                    end else if (w_any_coin) begin
                        if (w_credit_sum <= c_max_credit) begin
                            credit_d = w_credit_sum[9:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    state_d = (credit_d == 10'd0) ? ST_IDLE : ST_CREDIT;
                end
            end
        endcase
        refund_busy_d = (state_d == ST_REFUND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            credit_q        <= 10'd0;
            gap_q           <= '0;
            // History starts high so levels held through reset are not seen as edges.
            prev_q          <= 5'b11111;
            coin_reject_q   <= 1'b0;
            change_nickel_q <= 1'b0;
            refund_busy_q   <= 1'b0;
`ifdef COIN_COUNTER_QUARTER_CHANGE_EN
            change_quarter_q <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            gap_q           <= gap_d;
            prev_q          <= prev_d;
            coin_reject_q   <= coin_reject_d;
            change_nickel_q <= change_nickel_d;
            refund_busy_q   <= refund_busy_d;
`ifdef COIN_COUNTER_QUARTER_CHANGE_EN
            change_quarter_q <= change_quarter_d;
`endif
        end
    end

    assign bus.credit        = credit_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.change_nickel = change_nickel_q;
    assign bus.refund_busy   = refund_busy_q;
`ifdef COIN_COUNTER_QUARTER_CHANGE_EN
    assign bus.change_quarter = change_quarter_q;
`else
    assign bus.change_quarter = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coin_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_counter
//  Description : Self-checking bench for coin_counter. A cents-level model
//                (integer credit, refund flag, wait countdown) predicts every
//                output; directed scenarios plus a randomized run compare
//                the DUT against it and against hand-derived constants.
//                Honours COIN_COUNTER_QUARTER_CHANGE_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coin_counter;

    localparam int MAX_CREDIT = 995;
    localparam int REFUND_GAP = 4;
`ifdef COIN_COUNTER_QUARTER_CHANGE_EN
    localparam bit QCHG = 1'b1;
`else
    localparam bit QCHG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    coin_counter_if bus();

    coin_counter #(
        .MAX_CREDIT (MAX_CREDIT),
        .REFUND_GAP (REFUND_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int         m_credit;
    bit         m_refunding;
    int         m_wait;
    logic [4:0] m_prev;
    bit         e_reject, e_nickel, e_quarter;

    task automatic model_reset();
        m_credit    = 0;
        m_refunding = 1'b0;
        m_wait      = 0;
        m_prev      = 5'b11111;
        e_reject    = 1'b0;
        e_nickel    = 1'b0;
        e_quarter   = 1'b0;
    endtask

    task automatic model_update();
        logic [4:0] now;
        logic [4:0] ed;
        int         value;
        bit         any_coin;
        now = {bus.refund_req, bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel};
        ed     = now & ~m_prev;
        m_prev = now;
        value  = 0;
        if (ed[0]) value += 5;
        if (ed[1]) value += 10;
        if (ed[2]) value += 25;
        if (ed[3]) value += 100;
        any_coin  = (ed[3:0] != 4'b0000);
        e_reject  = 1'b0;
        e_nickel  = 1'b0;
        e_quarter = 1'b0;
        if (m_refunding) begin
            e_reject = any_coin;
            if (m_wait > 0) m_wait--;
            else if (QCHG && m_credit >= 25) begin
                m_credit -= 25; e_quarter = 1'b1; m_wait = REFUND_GAP - 1;
            end else if (m_credit >= 5) begin
                m_credit -= 5; e_nickel = 1'b1; m_wait = REFUND_GAP - 1;
            end else begin
                m_credit = 0; m_refunding = 1'b0;
            end
        end else if (ed[4] && m_credit > 0) begin
            m_refunding = 1'b1; m_wait = 0; e_reject = any_coin;
        end else if (bus.vend_done) begin
            m_credit = (int'(bus.change_in) > MAX_CREDIT) ? MAX_CREDIT : int'(bus.change_in);
            e_reject = any_coin;
        end else if (any_coin) begin
            if (m_credit + value <= MAX_CREDIT) m_credit += value;
            else e_reject = 1'b1;
        end
    endtask

    // One clock: model follows the DUT's edge, outputs are then sampled at negedge.
    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.coin_nickel  = 1'b0;
        bus.coin_dime    = 1'b0;
        bus.coin_quarter = 1'b0;
        bus.coin_dollar  = 1'b0;
        bus.refund_req   = 1'b0;
        bus.vend_done    = 1'b0;
        bus.change_in    = 10'd0;
    endtask

    task automatic set_coins(input logic [3:0] mask);
        {bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel} = mask;
    endtask

    // mask bits: {dollar, quarter, dime, nickel}
    task automatic insert(input logic [3:0] mask);
        set_coins(mask);
        step();
        set_coins(4'b0000);
        step();
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        checks += 5;
        if (bus.credit !== 10'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", bus.credit); end
        if (bus.coin_reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %b expected 0", bus.coin_reject); end
        if (bus.change_nickel !== 1'b0) begin errors++; $display("FAIL reset_nickel: got %b expected 0", bus.change_nickel); end
        if (bus.change_quarter !== 1'b0) begin errors++; $display("FAIL reset_quarter: got %b expected 0", bus.change_quarter); end
        if (bus.refund_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.refund_busy); end
    endtask

    task automatic test_coin_sequence();
        logic [3:0] masks [3];
        int         exp_c [3];
        masks = '{4'b0100, 4'b0010, 4'b0001};
        exp_c = '{25, 35, 40};
        rst = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            set_coins(masks[i]);
            step();
            checks += 2;
            if (bus.credit !== 10'(exp_c[i])) begin errors++; $display("FAIL seq_credit[%0d]: got %0d expected %0d", i, bus.credit, exp_c[i]); end
            if (bus.coin_reject !== 1'b0) begin errors++; $display("FAIL seq_reject[%0d]: got %b expected 0", i, bus.coin_reject); end
            set_coins(4'b0000);
            step();
        end
    endtask

    task automatic test_held_through_reset();
        clear_inputs();
        rst = 1'b0;
        set_coins(4'b1111);
        bus.refund_req = 1'b1;
        step();
        rst = 1'b1;
        step();
        step();
        checks += 2;
        if (bus.credit !== 10'd0) begin errors++; $display("FAIL held_credit: got %0d expected 0", bus.credit); end
        if (bus.coin_reject !== 1'b0) begin errors++; $display("FAIL held_reject: got %b expected 0", bus.coin_reject); end
        clear_inputs();
        step();
        checks++;
        if (bus.credit !== 10'd0) begin errors++; $display("FAIL held_release_credit: got %0d expected 0", bus.credit); end
    endtask

    task automatic test_multi_coin_overflow();
        apply_reset();
        set_coins(4'b0110);
        step();
        checks++;
        if (bus.credit !== 10'd35) begin errors++; $display("FAIL multi_credit: got %0d expected 35", bus.credit); end
        set_coins(4'b0000);
        step();
        for (int i = 0; i < 9; i++) insert(4'b1000);
        insert(4'b0100);
        insert(4'b0100);
        insert(4'b0001);
        checks++;
        if (bus.credit !== 10'd990) begin errors++; $display("FAIL fill_credit: got %0d expected 990", bus.credit); end
        set_coins(4'b0100);
        step();
        checks += 2;
        if (bus.coin_reject !== 1'b1) begin errors++; $display("FAIL over_reject: got %b expected 1", bus.coin_reject); end
        if (bus.credit !== 10'd990) begin errors++; $display("FAIL over_credit: got %0d expected 990", bus.credit); end
        set_coins(4'b0000);
        step();
        checks += 2;
        if (bus.coin_reject !== 1'b0) begin errors++; $display("FAIL over_reject_pulse: got %b expected 0", bus.coin_reject); end
        if (bus.credit !== 10'd990) begin errors++; $display("FAIL over_credit_hold: got %0d expected 990", bus.credit); end
    endtask

    task automatic test_vend();
        apply_reset();
        insert(4'b1000);
        bus.vend_done = 1'b1;
        bus.change_in = 10'd15;
        bus.coin_nickel = 1'b1;
        step();
        checks += 2;
        if (bus.credit !== 10'd15) begin errors++; $display("FAIL vend_credit: got %0d expected 15", bus.credit); end
        if (bus.coin_reject !== 1'b1) begin errors++; $display("FAIL vend_reject: got %b expected 1", bus.coin_reject); end
        clear_inputs();
        step();
        bus.vend_done = 1'b1;
        bus.change_in = 10'd0;
        step();
        clear_inputs();
        checks++;
        if (bus.credit !== 10'd0) begin errors++; $display("FAIL vend_zero_credit: got %0d expected 0", bus.credit); end
        // refund request with no credit must be ignored
        bus.refund_req = 1'b1;
        step();
        checks++;
        if (bus.refund_busy !== 1'b0) begin errors++; $display("FAIL idle_refund_busy: got %b expected 0", bus.refund_busy); end
        bus.refund_req = 1'b0;
        step();
        bus.vend_done = 1'b1;
        bus.change_in = 10'd1000;
        step();
        clear_inputs();
        checks++;
        if (bus.credit !== 10'd995) begin errors++; $display("FAIL vend_clamp: got %0d expected 995", bus.credit); end
        step();
    endtask

    task automatic test_refund();
        int  pulse_cyc [$];
        int  n_nickel;
        int  n_quarter;
        bit  inserted;
        bit  saw_reject;
        int  cyc;
        apply_reset();
        insert(4'b0100);
        insert(4'b0010);
        insert(4'b0001);
        bus.refund_req = 1'b1;
        step();
        bus.refund_req = 1'b0;
        checks++;
        if (bus.refund_busy !== 1'b1) begin errors++; $display("FAIL refund_enter_busy: got %b expected 1", bus.refund_busy); end
        n_nickel = 0; n_quarter = 0; inserted = 1'b0; saw_reject = 1'b0; cyc = 0;
        while (bus.refund_busy === 1'b1 && cyc < 80) begin
            if (!inserted && (n_nickel + n_quarter) == 2) begin
                bus.coin_nickel = 1'b1;
                inserted = 1'b1;
            end else begin
                bus.coin_nickel = 1'b0;
            end
            step();
            cyc++;
            checks += 3;
            if (bus.credit !== 10'(m_credit)) begin errors++; $display("FAIL refund_credit@%0d: got %0d expected %0d", cyc, bus.credit, m_credit); end
            if ({bus.change_quarter, bus.change_nickel} !== {e_quarter, e_nickel}) begin
                errors++; $display("FAIL refund_pulse@%0d: got q%b n%b expected q%b n%b", cyc, bus.change_quarter, bus.change_nickel, e_quarter, e_nickel);
            end
            if (bus.coin_reject !== e_reject) begin errors++; $display("FAIL refund_reject@%0d: got %b expected %b", cyc, bus.coin_reject, e_reject); end
            if (bus.coin_reject === 1'b1) saw_reject = 1'b1;
            if (bus.change_nickel === 1'b1) begin n_nickel++; pulse_cyc.push_back(cyc); end
            if (bus.change_quarter === 1'b1) begin n_quarter++; pulse_cyc.push_back(cyc); end
        end
        bus.coin_nickel = 1'b0;
        checks += 5;
        if (bus.refund_busy !== 1'b0) begin errors++; $display("FAIL refund_timeout: busy still %b after %0d cycles", bus.refund_busy, cyc); end
        if (bus.credit !== 10'd0) begin errors++; $display("FAIL refund_final_credit: got %0d expected 0", bus.credit); end
        if (n_nickel != (QCHG ? 3 : 8)) begin errors++; $display("FAIL refund_nickels: got %0d expected %0d", n_nickel, QCHG ? 3 : 8); end
        if (n_quarter != (QCHG ? 1 : 0)) begin errors++; $display("FAIL refund_quarters: got %0d expected %0d", n_quarter, QCHG ? 1 : 0); end
        if (!saw_reject) begin errors++; $display("FAIL refund_coin_reject: got 0 expected 1"); end
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            checks++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != REFUND_GAP) begin
                errors++; $display("FAIL refund_spacing[%0d]: got %0d expected %0d", i, pulse_cyc[i] - pulse_cyc[i-1], REFUND_GAP);
            end
        end
    endtask

    task automatic test_reset_mid_refund();
        int pulses;
        int cyc;
        apply_reset();
        insert(4'b0100);
        insert(4'b0010);
        insert(4'b0001);
        bus.refund_req = 1'b1;
        step();
        bus.refund_req = 1'b0;
        pulses = 0; cyc = 0;
        while (pulses < 2 && cyc < 30) begin
            step();
            cyc++;
            if (bus.change_nickel === 1'b1 || bus.change_quarter === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL midrst_prelude: got %0d pulses expected 2", pulses); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (bus.credit !== 10'd0) begin errors++; $display("FAIL midrst_credit: got %0d expected 0", bus.credit); end
        if (bus.refund_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.refund_busy); end
        step();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.change_nickel === 1'b1 || bus.change_quarter === 1'b1) pulses++;
        end
        checks += 2;
        if (pulses != 0) begin errors++; $display("FAIL midrst_pulses: got %0d expected 0", pulses); end
        if (bus.credit !== 10'd0) begin errors++; $display("FAIL midrst_after_credit: got %0d expected 0", bus.credit); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            bus.coin_nickel  = ($urandom_range(0, 3) == 0);
            bus.coin_dime    = ($urandom_range(0, 3) == 0);
            bus.coin_quarter = ($urandom_range(0, 3) == 0);
            bus.coin_dollar  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) bus.refund_req = ~bus.refund_req;
            bus.vend_done = ($urandom_range(0, 19) == 0);
            bus.change_in = 10'($urandom_range(0, 1023));
            step();
            checks += 5;
            if (bus.credit !== 10'(m_credit)) begin errors++; $display("FAIL rand_credit@%0d: got %0d expected %0d", i, bus.credit, m_credit); end
            if (bus.coin_reject !== e_reject) begin errors++; $display("FAIL rand_reject@%0d: got %b expected %b", i, bus.coin_reject, e_reject); end
            if (bus.change_nickel !== e_nickel) begin errors++; $display("FAIL rand_nickel@%0d: got %b expected %b", i, bus.change_nickel, e_nickel); end
            if (bus.change_quarter !== e_quarter) begin errors++; $display("FAIL rand_quarter@%0d: got %b expected %b", i, bus.change_quarter, e_quarter); end
            if (bus.refund_busy !== m_refunding) begin errors++; $display("FAIL rand_busy@%0d: got %b expected %b", i, bus.refund_busy, m_refunding); end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_coin_sequence();
        test_held_through_reset();
        test_multi_coin_overflow();
        test_vend();
        test_refund();
        test_reset_mid_refund();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/coin_counter.md
Name: coin_counter

Overview:
- Upstream credit stage for the beverage dispenser; sits directly ahead of it in the vending path.
- Detects coin insertions, accumulates credit in cents and drives it to the dispenser's 10-bit money input.
- Takes back the dispenser's remaining-money value after each vend.
- Pays out remaining credit as timed change pulses on a refund request.

Parameters:
- MAX_CREDIT, 995, upper credit limit in cents; a coin that would exceed it is rejected (must be ≤1023).
- REFUND_GAP, 4, clock cycles between successive change pulses during refund (≥2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- coin_nickel  in  1  level from coin mech; a rising edge means one 5c coin
- coin_dime  in  1  rising edge means one 10c coin
- coin_quarter  in  1  rising edge means one 25c coin
- coin_dollar  in  1  rising edge means one 100c coin
- refund_req  in  1  rising edge starts refund of all credit
- vend_done  in  1  one-cycle pulse from dispenser; a beverage was dispensed
- change_in  in  10  dispenser remaining-money value, valid when vend_done=1
- credit  out  10  current credit in cents; feeds dispenser money input
- coin_reject  out  1  one-cycle pulse; the coin edge this cycle was not credited
- change_nickel  out  1  one-cycle pulse; eject one 5c coin
- change_quarter  out  1  one-cycle pulse; eject one 25c coin (see Optional Feature)
- refund_busy  out  1  high while in REFUND

Behaviour:
- Reset (rst=0, asynchronous): credit=0, coin_reject=0, change_nickel=0, change_quarter=0, refund_busy=0.
  - State goes to IDLE, gap counter=0.
  - All edge-detect history registers are set to 1, so inputs held high through reset are not counted.
- Edge detect:
  - Each of coin_*, refund_req has a registered previous sample.
  - edge = input & ~prev.
  - Effect is visible one clock after the input is first sampled high.
- States: IDLE (credit=0), CREDIT (credit>0), REFUND.
- Coin handling in IDLE/CREDIT:
  - sum = 5·n + 10·d + 25·q + 100·$ over all coin edges this cycle, in 11-bit arithmetic.
  - If credit+sum ≤ MAX_CREDIT: credit += sum.
  - Otherwise credit is unchanged and coin_reject=1 for one cycle; all coins that cycle are rejected together.
- vend_done (IDLE/CREDIT):
  - credit <= change_in; this takes priority over coins in the same cycle.
  - Any coin edge in that cycle pulses coin_reject.
  - Next state is IDLE if change_in=0, else CREDIT.
  - change_in > MAX_CREDIT is clamped to MAX_CREDIT.
- Refund:
  - A refund_req edge in CREDIT enters REFUND.
  - A refund_req edge in IDLE is ignored.
  - refund_req has priority over vend_done and coins.
- In REFUND:
  - refund_busy=1.
  - All coin edges produce coin_reject.
  - vend_done is ignored.
  - The first change pulse is issued the cycle after entry; the gap counter then reloads to REFUND_GAP−1 and counts down to 0 before the next pulse.
  - Each pulse: credit −= 5 with change_nickel=1.
  - When credit < 5 at a pulse slot: credit is cleared to 0 (sub-nickel remainder forfeited), no pulse is issued, and the next state is IDLE.
  - At most one change pulse per cycle.
- credit changes only on clock edges. There is no other combinational path from inputs to outputs except that coin_reject, change_nickel and change_quarter are registered.
- Reset mid-refund aborts immediately: credit=0, no further pulses.

Optional Feature:
- Macro: COIN_COUNTER_QUARTER_CHANGE_EN.
- Defined:
  - At each refund pulse slot, if credit ≥ 25: change_quarter=1 and credit −= 25.
  - Else if credit ≥ 5: change_nickel=1 and credit −= 5.
- Undefined: change_quarter is tied to 0 and the refund uses nickels only.
- The port list is identical in both builds.

Test Plan:
- Reset with all coins low, release rst; then a quarter edge, dime edge and nickel edge on separate cycles -> credit 0→25→35→40, coin_reject never asserted.
- Coin inputs held high through reset release -> no credit added; credit stays 0.
- Dime and quarter edges in the same cycle at credit=0 -> credit=35. Then drive to credit=990 and insert a quarter -> coin_reject single pulse, credit stays 990.
- credit=100, vend_done pulse with change_in=15 and a simultaneous nickel edge -> credit=15, coin_reject=1. A following vend_done with change_in=0 -> credit=0, state IDLE.
- credit=40, refund_req edge, REFUND_GAP=4, macro undefined -> 8 change_nickel pulses spaced 4 cycles; credit 35,30,…,0; refund_busy deasserts after the last; a coin inserted mid-refund pulses coin_reject.
- Macro defined, credit=40, refund -> one change_quarter then 3 change_nickel pulses. Separately, assert rst after the 2nd pulse -> credit=0 and no further pulses.
